// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB colour path (converter -> PWM driver).
package rgb_pkg;
   localparam int CH_W      = 8;
   localparam int RGB_W     = 24;
   localparam int PWM_STEPS = 255;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   // A prescaler of 1 still needs a 1-bit register to keep the logic uniform.
   function automatic int pre_width(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction
endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM channel: shadow duty register reloaded on the load strobe, registered compare output.
module pwm_channel
   import rgb_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_enable,
   input  logic            i_load,
   input  logic [CH_W-1:0] i_duty,
   input  logic [CH_W-1:0] i_cnt,
   output logic            o_led
);
   logic [CH_W-1:0] r_duty;
   logic            r_led;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty <= '0;
         r_led  <= 1'b0;
      end else if (!i_enable) begin
         // While idle the shadow tracks the input so the first period uses fresh data.
         r_duty <= i_duty;
         r_led  <= 1'b0;
      end else begin
         r_led <= (i_cnt < r_duty);
         if (i_load) begin
            r_duty <= i_duty;
         end
      end
   end

   assign o_led = r_led;
endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB LED PWM driver with period-aligned duty reload and a period_start pulse.
module rgb_pwm_driver
   import rgb_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [RGB_W-1:0] rgb,
   output logic             led_r,
   output logic             led_g,
   output logic             led_b,
   output logic             period_start
);
   localparam int              PRE_W    = pre_width(PRESCALE);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [CH_W-1:0]  CNT_LAST = CH_W'(PWM_STEPS - 1);

   logic [PRE_W-1:0] r_pre;
   logic [CH_W-1:0]  r_cnt;
   logic             r_period_start;
   logic             w_tick;
   logic             w_wrap;
   logic [2:0]       w_led;

   assign w_tick = (r_pre == PRE_LAST);
   assign w_wrap = w_tick && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre          <= '0;
         r_cnt          <= '0;
         r_period_start <= 1'b0;
      end else if (!enable) begin
         r_pre          <= '0;
         r_cnt          <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_pre          <= w_tick ? '0 : r_pre + 1'b1;
         r_period_start <= w_wrap;
         if (w_tick) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         end
      end
   end

   // Channel 0 is blue (rgb[7:0]), channel 2 is red (rgb[23:16]).
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ch
         pwm_channel u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_enable (enable),
            .i_load   (w_wrap),
            .i_duty   (rgb[gi*CH_W +: CH_W]),
            .i_cnt    (r_cnt),
            .o_led    (w_led[gi])
         );
      end
   endgenerate

   assign led_r        = w_led[2];
   assign led_g        = w_led[1];
   assign led_b        = w_led[0];
   assign period_start = r_period_start;
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver, one instance at PRESCALE=1 and one at PRESCALE=4.
module tb_rgb_pwm_driver;
   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [23:0] rgb;
   logic        r1, g1, b1, ps1;
   logic        r4, g4, b4, ps4;
   int          n_tests;
   int          n_fail;

   rgb_pwm_driver #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rgb(rgb),
      .led_r(r1), .led_g(g1), .led_b(b1), .period_start(ps1)
   );

   rgb_pwm_driver #(.PRESCALE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rgb(rgb),
      .led_r(r4), .led_g(g4), .led_b(b4), .period_start(ps4)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] outs(input int sel);
      return (sel == 0) ? {ps1, r1, g1, b1} : {ps4, r4, g4, b4};
   endfunction

   task automatic wait_ps(input int sel, input int budget, output bit ok);
      logic [3:0] o;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         o = outs(sel);
         if (o[3]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Call right after the negedge that saw period_start; samples exactly one period.
   task automatic measure(input int sel, input int len, output int hr, output int hg,
                          output int hb, output int ps_cnt, output bit ps_last,
                          output int r_fall);
      logic [3:0] o;
      hr = 0; hg = 0; hb = 0; ps_cnt = 0; ps_last = 1'b0; r_fall = -1;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         o = outs(sel);
         hr += int'(o[2]);
         hg += int'(o[1]);
         hb += int'(o[0]);
         ps_cnt += int'(o[3]);
         if (!o[2] && r_fall < 0) r_fall = i;
         if (i == len - 1) ps_last = o[3];
      end
   endtask

   task automatic load_disabled(input logic [23:0] val);
      @(negedge clk);
      enable = 1'b0;
      rgb    = val;
      repeat (2) @(negedge clk);
      enable = 1'b1;
   endtask

   task automatic test_reset_initial;
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({r1, g1, b1, ps1, r4, g4, b4, ps4} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_initial: got %b required 00000000", {r1, g1, b1, ps1, r4, g4, b4, ps4});
      end
      #20;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_p1;
      bit ok, pl;
      int hr, hg, hb, pc, rf;
      load_disabled(24'h80_00_FF);
      wait_ps(0, 300, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL basic_wait_ps: got 0 required 1"); end
      measure(0, 255, hr, hg, hb, pc, pl, rf);
      n_tests++;
      if (hr !== 128) begin n_fail++; $display("FAIL basic_r_high: got %0d required 128", hr); end
      n_tests++;
      if (rf !== 128) begin n_fail++; $display("FAIL basic_r_fall: got %0d required 128", rf); end
      n_tests++;
      if (hg !== 0) begin n_fail++; $display("FAIL basic_g_high: got %0d required 0", hg); end
      n_tests++;
      if (hb !== 255) begin n_fail++; $display("FAIL basic_b_high: got %0d required 255", hb); end
      n_tests++;
      if (pc !== 1 || pl !== 1'b1) begin
         n_fail++; $display("FAIL basic_ps_spacing: got cnt=%0d last=%0d required cnt=1 last=1", pc, pl);
      end
   endtask

   task automatic test_prescale4;
      bit ok, pl;
      int hr, hg, hb, pc, rf;
      load_disabled(24'h01_FE_10);
      wait_ps(1, 1100, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL p4_wait_ps: got 0 required 1"); end
      for (int p = 0; p < 2; p++) begin
         measure(1, 1020, hr, hg, hb, pc, pl, rf);
         n_tests++;
         if (hr !== 4 || rf !== 4) begin
            n_fail++; $display("FAIL p4_r_high: got %0d fall=%0d required 4 fall=4", hr, rf);
         end
         n_tests++;
         if (hg !== 1016) begin n_fail++; $display("FAIL p4_g_high: got %0d required 1016", hg); end
         n_tests++;
         if (hb !== 64) begin n_fail++; $display("FAIL p4_b_high: got %0d required 64", hb); end
         n_tests++;
         if (pc !== 1 || pl !== 1'b1) begin
            n_fail++; $display("FAIL p4_ps_spacing: got cnt=%0d last=%0d required cnt=1 last=1", pc, pl);
         end
      end
   endtask

   task automatic test_mid_change;
      bit ok, pl;
      int hr, hg, hb, pc, rf;
      load_disabled(24'h40_40_40);
      wait_ps(0, 300, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL mid_wait_ps: got 0 required 1"); end
      hr = 0; pc = 0; pl = 1'b0;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         hr += int'(r1);
         pc += int'(ps1);
         if (i == 254) pl = ps1;
         if (i == 100) rgb = 24'hC0_C0_C0;
      end
      n_tests++;
      if (hr !== 64) begin n_fail++; $display("FAIL mid_current_period: got %0d required 64", hr); end
      n_tests++;
      if (pc !== 1 || pl !== 1'b1) begin
         n_fail++; $display("FAIL mid_ps: got cnt=%0d last=%0d required cnt=1 last=1", pc, pl);
      end
      measure(0, 255, hr, hg, hb, pc, pl, rf);
      n_tests++;
      if (hr !== 192 || hg !== 192 || hb !== 192) begin
         n_fail++; $display("FAIL mid_next_period: got r=%0d g=%0d b=%0d required 192", hr, hg, hb);
      end
   endtask

   task automatic test_enable_toggle;
      bit ok, pl;
      int hr, hg, hb, pc, rf, bad;
      rgb = 24'hFF_FF_FF;
      wait_ps(0, 300, ok);
      repeat (50) @(negedge clk);
      n_tests++;
      if (r1 !== 1'b1) begin n_fail++; $display("FAIL en_running: got %0d required 1", r1); end
      enable = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({r1, g1, b1, ps1} !== 4'b0000) begin
         n_fail++; $display("FAIL en_drop: got %b required 0000", {r1, g1, b1, ps1});
      end
      rgb = 24'h0A_0A_0A;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ({r1, g1, b1, ps1} !== 4'b0000) bad++;
      end
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL en_idle: got %0d active cycles required 0", bad); end
      enable = 1'b1;
      measure(0, 255, hr, hg, hb, pc, pl, rf);
      n_tests++;
      if (hr !== 10 || rf !== 10 || hb !== 10) begin
         n_fail++; $display("FAIL en_restart: got r=%0d fall=%0d b=%0d required 10", hr, rf, hb);
      end
      n_tests++;
      if (pc !== 1 || pl !== 1'b1) begin
         n_fail++; $display("FAIL en_restart_ps: got cnt=%0d last=%0d required cnt=1 last=1", pc, pl);
      end
   endtask

   task automatic test_boundary;
      bit ok, pl;
      int hr, hg, hb, pc, rf;
      load_disabled(24'hFF_00_FF);
      wait_ps(0, 300, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL bnd_wait_ps: got 0 required 1"); end
      for (int p = 0; p < 3; p++) begin
         measure(0, 255, hr, hg, hb, pc, pl, rf);
         n_tests++;
         if (hr !== 255 || hb !== 255 || hg !== 0 || pl !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_period%0d: got r=%0d g=%0d b=%0d ps=%0d required 255/0/255/1", p, hr, hg, hb, pl);
         end
      end
   endtask

   task automatic test_reset_midrun;
      @(negedge clk);
      n_tests++;
      if (r1 !== 1'b1 || r4 !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre: got r1=%0d r4=%0d required 1", r1, r4);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({r1, g1, b1, ps1, r4, g4, b4, ps4} !== 8'h00) begin
         n_fail++; $display("FAIL rst_async: got %b required 00000000", {r1, g1, b1, ps1, r4, g4, b4, ps4});
      end
      @(negedge clk);
      enable = 1'b0;
      rst_n  = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({r1, b1, ps1, r4, b4, ps4} !== 6'b000000) begin
         n_fail++; $display("FAIL rst_release_idle: got %b required 000000", {r1, b1, ps1, r4, b4, ps4});
      end
   endtask

   initial begin
      clk     = 1'b0;
      rst_n   = 1'b1;
      enable  = 1'b0;
      rgb     = 24'h0;
      n_tests = 0;
      n_fail  = 0;
      test_reset_initial();
      test_basic_p1();
      test_prescale4();
      test_mid_change();
      test_enable_toggle();
      test_boundary();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
